// File: rtl/wait_pattern_checker.sv
// wait_pattern_checker
//   Receive-side checker for the two-pulse wait waveform. After `start`
//   falls, the line must read: low (LEAD), high (HIGH1), low (GAP),
//   high (HIGH2), then stay low for TAIL_LEN cycles. Each closed phase is
//   measured and compared against its expected length within +/-TOL.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   start     generator hold/restart; high = hold, falling edge begins a check
//   sig_in    waveform under check
//   busy      high while a check is in progress
//   done      one-cycle pulse when a check finishes (pass or fail)
//   pass      result, valid from done until the next check begins
//   err_code  0 none, 1 lead, 2 high1, 3 gap, 4 high2, 5 tail glitch, 6 timeout
//   last_len  measured length of the most recently closed phase
module wait_pattern_checker #(
  parameter logic [15:0] LEAD_LEN    = 16'h4000,
  parameter logic [15:0] HIGH_LEN    = 16'h4000,
  parameter logic [15:0] GAP_LEN     = 16'h4000,
  parameter logic [15:0] TAIL_LEN    = 16'h0010,
  parameter logic [15:0] TOL         = 16'h0002,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sig_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  err_code,
  output logic [15:0] last_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_LEAD,
    S_HIGH1,
    S_GAP,
    S_HIGH2,
    S_TAIL
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEAD    = 3'd1;
  localparam logic [2:0] ERR_HIGH1   = 3'd2;
  localparam logic [2:0] ERR_GAP     = 3'd3;
  localparam logic [2:0] ERR_HIGH2   = 3'd4;
  localparam logic [2:0] ERR_TAIL    = 3'd5;
  localparam logic [2:0] ERR_TIMEOUT = 3'd6;

  // ------------------------------------------------------------------
  // Input synchronisers. Both lines get the same depth so the relative
  // timing between start and sig_in is preserved.
  // ------------------------------------------------------------------
  logic start_s;
  logic sig_s;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign start_s = start;
    assign sig_s   = sig_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] start_sync_q;
    logic [SYNC_STAGES-1:0] sig_sync_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        start_sync_q <= '0;
        sig_sync_q   <= '0;
      end else begin
        start_sync_q[0] <= start;
        sig_sync_q[0]   <= sig_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          start_sync_q[i] <= start_sync_q[i-1];
          sig_sync_q[i]   <= sig_sync_q[i-1];
        end
      end
    end

    assign start_s = start_sync_q[SYNC_STAGES-1];
    assign sig_s   = sig_sync_q[SYNC_STAGES-1];
  end

  // |count - expected| <= TOL, computed 17 bits wide so it cannot wrap.
  function automatic logic within_tol(input logic [15:0] cnt,
                                      input logic [15:0] expv);
    logic [16:0] diff;
    if (cnt >= expv) diff = {1'b0, cnt} - {1'b0, expv};
    else             diff = {1'b0, expv} - {1'b0, cnt};
    return (diff <= {1'b0, TOL});
  endfunction

  // ------------------------------------------------------------------
  // State and result registers
  // ------------------------------------------------------------------
  state_e      state_q,    state_d;
  logic [15:0] cnt_q,      cnt_d;
  logic        done_q,     done_d;
  logic        pass_q,     pass_d;
  logic [2:0]  err_q,      err_d;
  logic [15:0] last_len_q, last_len_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= ERR_NONE;
      last_len_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      last_len_q <= last_len_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  logic [15:0] cnt_inc;
  logic        ph_level;   // line level that keeps the current phase open
  logic [15:0] ph_exp;
  logic [2:0]  ph_code;
  state_e      ph_next;

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    ph_level = 1'b0;
    ph_exp   = LEAD_LEN;
    ph_code  = ERR_LEAD;
    ph_next  = S_HIGH1;
    case (state_q)
      S_HIGH1: begin ph_level = 1'b1; ph_exp = HIGH_LEN; ph_code = ERR_HIGH1; ph_next = S_GAP;   end
      S_GAP:   begin ph_level = 1'b0; ph_exp = GAP_LEN;  ph_code = ERR_GAP;   ph_next = S_HIGH2; end
      S_HIGH2: begin ph_level = 1'b1; ph_exp = HIGH_LEN; ph_code = ERR_HIGH2; ph_next = S_TAIL;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    last_len_d = last_len_q;

    case (state_q)
      S_IDLE: begin
        if (start_s) state_d = S_ARMED;
      end

      S_ARMED: begin
        // The first start-low cycle is already the first LEAD cycle.
        if (!start_s) begin
          state_d = S_LEAD;
          cnt_d   = 16'd1;
          pass_d  = 1'b0;
          err_d   = ERR_NONE;
        end
      end

      S_LEAD, S_HIGH1, S_GAP, S_HIGH2: begin
        // Abort takes priority over any phase close or timeout.
        if (start_s) begin
          state_d = S_ARMED;
        end else if (sig_s != ph_level) begin
          last_len_d = cnt_q;
          if (within_tol(cnt_q, ph_exp)) begin
            state_d = ph_next;
            cnt_d   = 16'd1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = ph_code;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 16'hFFFF) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            err_d   = ERR_TIMEOUT;
          end
        end
      end

      S_TAIL: begin
        if (start_s) begin
          state_d = S_ARMED;
        end else if (sig_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = ERR_TAIL;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TAIL_LEN) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
            err_d   = ERR_NONE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q inside {S_LEAD, S_HIGH1, S_GAP, S_HIGH2, S_TAIL});
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_code = err_q;
  assign last_len = last_len_q;

endmodule

// File: tb/tb_wait_pattern_checker.sv
// tb_wait_pattern_checker
//   Directed bench for wait_pattern_checker with short phase lengths
//   (LEAD/HIGH/GAP = 16, TAIL = 8, TOL = 1, two sync stages).
module tb_wait_pattern_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sig_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  err_code;
  logic [15:0] last_len;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  logic        done_prev = 1'b0;

  always #5 clk = ~clk;

  wait_pattern_checker #(
    .LEAD_LEN   (16'd16),
    .HIGH_LEN   (16'd16),
    .GAP_LEN    (16'd16),
    .TAIL_LEN   (16'd8),
    .TOL        (16'd1),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sig_in  (sig_in),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_code(err_code),
    .last_len(last_len)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Every done pulse: busy must already be low and done must not repeat.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check_eq("done_busy_low", {31'd0, busy}, 32'd0);
      check_eq("done_not_consecutive", {31'd0, done_prev}, 32'd0);
    end
    done_prev = done;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drop start (assumed high) and play the five phases on sig_in.
  task automatic wave(input int lead, input int h1, input int gap,
                      input int h2, input int tail);
    start = 1'b0; sig_in = 1'b0; hold(lead);
    sig_in = 1'b1; hold(h1);
    sig_in = 1'b0; hold(gap);
    sig_in = 1'b1; hold(h2);
    sig_in = 1'b0; hold(tail);
  endtask

  task automatic arm();
    start = 1'b1; sig_in = 1'b0; hold(4);
  endtask

  task automatic expect_result(input string tag, input int unsigned base,
                               input logic p, input logic [2:0] e,
                               input logic [15:0] len, input bit chk_len);
    check_eq({tag, "_done_count"}, done_cnt - base, 32'd1);
    check_eq({tag, "_pass"}, {31'd0, pass}, {31'd0, p});
    check_eq({tag, "_err"}, {29'd0, err_code}, {29'd0, e});
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (chk_len) check_eq({tag, "_last_len"}, {16'd0, last_len}, {16'd0, len});
  endtask

  initial begin
    int unsigned base;
    int n;

    rst = 1'b1; start = 1'b0; sig_in = 1'b0;
    hold(3);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_pass", {31'd0, pass}, 32'd0);
    check_eq("rst_err", {29'd0, err_code}, 32'd0);
    check_eq("rst_last_len", {16'd0, last_len}, 32'd0);
    rst = 1'b0;
    hold(2);

    // Nominal
    base = done_cnt;
    arm(); wave(16, 16, 16, 16, 12); hold(4);
    expect_result("nominal", base, 1'b1, 3'd0, 16'd16, 1'b1);

    // Tolerance edges that still pass
    base = done_cnt;
    arm(); wave(17, 15, 16, 16, 12); hold(4);
    expect_result("tol_pass", base, 1'b1, 3'd0, 16'd16, 1'b1);

    // Gap just outside tolerance
    base = done_cnt;
    arm(); wave(16, 16, 18, 16, 12); hold(4);
    expect_result("gap_fail", base, 1'b0, 3'd3, 16'd18, 1'b1);

    // Tail glitch three cycles into the tail
    base = done_cnt;
    arm(); wave(16, 16, 16, 16, 3);
    sig_in = 1'b1; hold(1);
    sig_in = 1'b0; hold(10);
    expect_result("tail_glitch", base, 1'b0, 3'd5, 16'd0, 1'b0);

    // Timeout in LEAD
    base = done_cnt;
    arm();
    start = 1'b0; sig_in = 1'b0;
    n = 0;
    while (!done && n < 70000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("timeout_seen", {31'd0, done}, 32'd1);
    check_eq("timeout_window", {31'd0, (n >= 65530 && n <= 65545)}, 32'd1);
    hold(2);
    expect_result("timeout", base, 1'b0, 3'd6, 16'd0, 1'b0);

    // Abort during GAP, then restart
    base = done_cnt;
    arm();
    start = 1'b0; sig_in = 1'b0; hold(16);
    sig_in = 1'b1; hold(16);
    sig_in = 1'b0; hold(5);
    start = 1'b1; hold(4);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_no_done", done_cnt - base, 32'd0);
    check_eq("abort_err", {29'd0, err_code}, 32'd0);
    check_eq("abort_pass", {31'd0, pass}, 32'd0);
    wave(16, 16, 16, 16, 12); hold(4);
    expect_result("restart", base, 1'b1, 3'd0, 16'd16, 1'b1);

    // Reset in the middle of HIGH1
    base = done_cnt;
    arm();
    start = 1'b0; sig_in = 1'b0; hold(16);
    sig_in = 1'b1; hold(8);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; hold(1);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_pass", {31'd0, pass}, 32'd0);
    check_eq("midrst_err", {29'd0, err_code}, 32'd0);
    check_eq("midrst_last_len", {16'd0, last_len}, 32'd0);
    rst = 1'b0; sig_in = 1'b0; hold(4);
    check_eq("midrst_no_done", done_cnt - base, 32'd0);
    check_eq("midrst_idle", {31'd0, busy}, 32'd0);
    arm(); wave(16, 16, 16, 16, 12); hold(4);
    expect_result("after_rst", base, 1'b1, 3'd0, 16'd16, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
